// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer mode encoding, step indices and $4017 field positions.
package apu_pkg;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

    localparam int unsigned MODE_BIT    = 7;
    localparam int unsigned INHIBIT_BIT = 6;

    typedef enum logic [2:0] {
        STEP0 = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4
    } step_e;

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Frame sequencer bus: CPU tick, $4017 write path, IRQ ack and the frame strobes.
interface apu_frame_sequencer_if;

    logic       iTick;
    logic       iWrite;
    logic [7:0] iData;
    logic       iIrqAck;
    logic       oQuarterFrame;
    logic       oHalfFrame;
    logic       oIrq;
    logic       oMode;

    modport slave (
        input  iTick,
        input  iWrite,
        input  iData,
        input  iIrqAck,
        output oQuarterFrame,
        output oHalfFrame,
        output oIrq,
        output oMode
    );

    modport master (
        output iTick,
        output iWrite,
        output iData,
        output iIrqAck,
        input  oQuarterFrame,
        input  oHalfFrame,
        input  oIrq,
        input  oMode
    );

endinterface

// File: rtl/apu_frame_sequencer_frame_divider.sv
// STEP_PERIOD prescaler on the CPU tick; the clear input restarts the count and swallows that tick.
module frame_divider #(
    parameter int unsigned STEP_PERIOD = 7457
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iTick,
    input  logic iClear,
    output logic oStep_c
);

    localparam int unsigned CNT_W = $clog2(STEP_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap  = (r_cnt == CNT_LAST);
    assign oStep_c = iTick && !iClear && w_wrap;

    always_ff @(posedge iClk) begin
        if (iReset || iClear) begin
            r_cnt <= '0;
        end else if (iTick) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apu_frame_sequencer.sv
// NES APU frame sequencer: quarter/half-frame strobes, 4/5-step mode and frame IRQ.
// Build option: define FRAME_SEQ_IRQ_EN to include the IRQ flag, inhibit bit and ack path.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int unsigned STEP_PERIOD = 7457
) (
    input logic                   iClk,
    input logic                   iReset,
    apu_frame_sequencer_if.slave  bus
);

    step_e r_step;
    step_e w_step_nxt;
    logic  r_mode;
    logic  w_mode_nxt;
    logic  r_quarter;
    logic  w_quarter_nxt;
    logic  r_half;
    logic  w_half_nxt;
    logic  w_step_c;

    frame_divider #(
        .STEP_PERIOD (STEP_PERIOD)
    ) u_divider (
        .iClk    (iClk),
        .iReset  (iReset),
        .iTick   (bus.iTick),
        .iClear  (bus.iWrite),
        .oStep_c (w_step_c)
    );

`ifdef FRAME_SEQ_IRQ_EN
    logic r_inhibit;
    logic w_inhibit_nxt;
    logic r_irq;
    logic w_irq_nxt;
    logic w_unused;

    assign w_unused = ^{1'b0, bus.iData[5:0]};
`else
    logic w_unused;

    assign w_unused = ^{1'b0, bus.iData[6:0], bus.iIrqAck};
`endif

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_step    <= STEP0;
            r_mode    <= MODE_4STEP;
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
        end else begin
            r_step    <= w_step_nxt;
            r_mode    <= w_mode_nxt;
            r_quarter <= w_quarter_nxt;
            r_half    <= w_half_nxt;
        end
    end

`ifdef FRAME_SEQ_IRQ_EN
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_inhibit <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_inhibit <= w_inhibit_nxt;
            r_irq     <= w_irq_nxt;
        end
    end
`endif

    // Next step and fire map; a write restarts the sequence and overrides the step strobe.
    always_comb begin
        w_step_nxt    = r_step;
        w_mode_nxt    = r_mode;
        w_quarter_nxt = 1'b0;
        w_half_nxt    = 1'b0;
`ifdef FRAME_SEQ_IRQ_EN
        w_inhibit_nxt = r_inhibit;
        w_irq_nxt     = r_irq;
        if (bus.iIrqAck) begin
            w_irq_nxt = 1'b0;
        end
`endif
        if (bus.iWrite) begin
            w_step_nxt    = STEP0;
            w_mode_nxt    = bus.iData[MODE_BIT];
            w_quarter_nxt = bus.iData[MODE_BIT];
            w_half_nxt    = bus.iData[MODE_BIT];
`ifdef FRAME_SEQ_IRQ_EN
            w_inhibit_nxt = bus.iData[INHIBIT_BIT];
            if (bus.iData[INHIBIT_BIT]) begin
                w_irq_nxt = 1'b0;
            end
`endif
        end else if (w_step_c) begin
            case (r_step)
                STEP0: begin
                    w_quarter_nxt = 1'b1;
                    w_step_nxt    = STEP1;
                end
                STEP1: begin
                    w_quarter_nxt = 1'b1;
                    w_half_nxt    = 1'b1;
                    w_step_nxt    = STEP2;
                end
                STEP2: begin
                    w_quarter_nxt = 1'b1;
                    w_step_nxt    = STEP3;
                end
                STEP3: begin
                    if (r_mode == MODE_5STEP) begin
                        w_step_nxt = STEP4;
                    end else begin
                        w_quarter_nxt = 1'b1;
                        w_half_nxt    = 1'b1;
                        w_step_nxt    = STEP0;
`ifdef FRAME_SEQ_IRQ_EN
                        if (!r_inhibit) begin
                            w_irq_nxt = 1'b1;
                        end
`endif
                    end
                end
                STEP4: begin
                    w_quarter_nxt = 1'b1;
                    w_half_nxt    = 1'b1;
                    w_step_nxt    = STEP0;
                end
                default: begin
                    w_step_nxt = STEP0;
                end
            endcase
        end
    end

    assign bus.oQuarterFrame = r_quarter;
    assign bus.oHalfFrame    = r_half;
    assign bus.oMode         = r_mode;
`ifdef FRAME_SEQ_IRQ_EN
    assign bus.oIrq          = r_irq;
`else
    assign bus.oIrq          = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with STEP_PERIOD=4; IRQ expectations follow FRAME_SEQ_IRQ_EN.
module tb_apu_frame_sequencer;

    localparam int unsigned STEP_PERIOD = 4;
`ifdef FRAME_SEQ_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic iClk;
    logic iReset;
    int   n_vec;
    int   n_miss;

    apu_frame_sequencer_if bus ();

    apu_frame_sequencer #(
        .STEP_PERIOD (STEP_PERIOD)
    ) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic q, input logic h,
                              input logic irq, input logic mode);
        check_eq({tag, ".q"},    bus.oQuarterFrame, q);
        check_eq({tag, ".h"},    bus.oHalfFrame,    h);
        check_eq({tag, ".irq"},  bus.oIrq,          irq);
        check_eq({tag, ".mode"}, bus.oMode,         mode);
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] data);
        bus.iWrite = 1'b1;
        bus.iData  = data;
        cyc();
        bus.iWrite = 1'b0;
        bus.iData  = 8'h00;
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        iReset         = 1'b1;
        bus.iTick      = 1'b0;
        bus.iWrite     = 1'b0;
        bus.iData      = 8'h00;
        bus.iIrqAck    = 1'b0;
        #1;
        cyc();
        cyc();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // 4-step frame from reset
        iReset    = 1'b0;
        bus.iTick = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check_outs($sformatf("f4_t%0d", k), (k % 4) == 0, (k % 8) == 0,
                       IRQ_EN && (k == 16), 1'b0);
        end
        for (int k = 17; k <= 19; k++) begin
            cyc();
            check_outs($sformatf("f4_hold_t%0d", k), 1'b0, 1'b0, IRQ_EN, 1'b0);
        end

        // Ack drops the flag next cycle
        bus.iTick   = 1'b0;
        bus.iIrqAck = 1'b1;
        cyc();
        bus.iIrqAck = 1'b0;
        check_outs("ack", 1'b0, 1'b0, 1'b0, 1'b0);

        // 5-step write with a concurrent tick: immediate Q+H, tick dropped
        bus.iTick = 1'b1;
        write_reg(8'h80);
        check_outs("w80", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            check_outs($sformatf("f5_t%0d", k), ((k % 4) == 0) && (k != 16),
                       (k == 8) || (k == 20), 1'b0, 1'b1);
        end

        // Inhibited 4-step frame: strobes unchanged, no IRQ
        write_reg(8'h40);
        check_outs("w40", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check_outs($sformatf("inh_t%0d", k), (k % 4) == 0, (k % 8) == 0, 1'b0, 1'b0);
        end

        // Ack on the setting cycle: set wins
        write_reg(8'h00);
        check_outs("w00", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            bus.iIrqAck = (k == 16);
            cyc();
            check_outs($sformatf("ackset_t%0d", k), (k % 4) == 0, (k % 8) == 0,
                       IRQ_EN && (k == 16), 1'b0);
        end
        bus.iIrqAck = 1'b0;

        // Inhibit write while flag is high clears it
        write_reg(8'h40);
        check_outs("w40_clr", 1'b0, 1'b0, 1'b0, 1'b0);

        // Tick gap of 10 cycles delays the next Q by 10
        for (int k = 1; k <= 2; k++) begin
            cyc();
            check_outs($sformatf("gap_pre%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.iTick = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check_outs($sformatf("gap_idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.iTick = 1'b1;
        cyc();
        check_outs("gap_t3", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_outs("gap_t4", 1'b1, 1'b0, 1'b0, 1'b0);

        // Write coinciding with tick 4 drops step 0 and restarts
        write_reg(8'h00);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check_outs($sformatf("wt_pre%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        write_reg(8'h00);
        check_outs("wt_t4", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check_outs($sformatf("wt_post%0d", k), k == 4, 1'b0, 1'b0, 1'b0);
        end

        // Reset at tick 7, then first Q after 4 ticks
        iReset = 1'b1;
        cyc();
        iReset = 1'b0;
        check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check_outs($sformatf("rst_t%0d", k), k == 4, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Frame sequencer for the NES APU: divides the CPU-cycle tick into quarter-frame and half-frame strobes and raises the frame IRQ. It sits directly upstream of linear_counter: oQuarterFrame drives its iEnable. It also feeds the envelope, length-counter and sweep units. The $4017 register write path selects 4-step or 5-step mode and IRQ inhibit.

## Interface
- STEP_PERIOD, 7457, CPU ticks per sequencer step; minimum 2
- iClk  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iTick  in  1  one-iClk enable per CPU cycle
- iWrite  in  1  $4017 write strobe, one iClk wide
- iData  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit; other bits ignored
- iIrqAck  in  1  $4015 read strobe; clears frame IRQ flag
- oQuarterFrame  out  1  one-iClk pulse per quarter frame
- oHalfFrame  out  1  one-iClk pulse per half frame
- oIrq  out  1  frame IRQ flag, level
- oMode  out  1  current mode bit

## Operation
- Divider cnt is $clog2(STEP_PERIOD) bits wide and counts 0..STEP_PERIOD-1 on iTick.
- On iTick with cnt==STEP_PERIOD-1: cnt←0 and the current step fires. Step index advances and wraps after 3 in 4-step mode, or after 4 in 5-step mode.
- 4-step fire map:
  - step 0: Q
  - step 1: Q+H
  - step 2: Q
  - step 3: Q+H, and IRQ set if inhibit==0
- 5-step fire map:
  - step 0: Q
  - step 1: Q+H
  - step 2: Q
  - step 3: nothing
  - step 4: Q+H
  - IRQ is never set in 5-step mode.
- States: STEP0..STEP4. STEP4 is reachable only with mode==1.
- Write (iWrite):
  - cnt←0, step←STEP0, mode←iData[7], inhibit←iData[6].
  - If iData[7]==1, Q and H both pulse once immediately.
  - If iData[6]==1, the IRQ flag clears.
- IRQ flag:
  - Set only by the step-3 event.
  - Cleared by iIrqAck or by a write with inhibit=1.
  - Holds otherwise.

## Timing
- All outputs are registered. A Q/H pulse appears on the iClk after the firing tick or the write, and is exactly one iClk wide.
- oIrq rises on the same edge as the step-3 Q/H pulse.
- Reset values: cnt=0, step=STEP0, mode=0, inhibit=0, oQuarterFrame=0, oHalfFrame=0, oIrq=0, oMode=0.
- Simultaneous events:
  - iWrite and iTick in the same cycle: the write wins and that tick is dropped.
  - iIrqAck and an IRQ set in the same cycle: set wins.
  - A write with inhibit=1 and an IRQ set in the same cycle: clear wins, because the write resets the sequence and the step does not fire.
- iTick low: divider and step hold, no pulses.
- Mode change mid-frame restarts the sequence from STEP0; no stale step fires.
- iReset mid-operation: returns to the reset values on the next edge and suppresses any pending pulse.

## Configuration
- FRAME_SEQ_IRQ_EN
  - Defined: IRQ flag, inhibit register and iIrqAck logic are present as specified.
  - Undefined: oIrq is tied 0, iIrqAck and iData[6] are ignored, and no flag flop is built. Q/H behaviour is unchanged.

## Structure
- Shared package apu_pkg holds:
  - mode encoding constants MODE_4STEP=0 and MODE_5STEP=1
  - step index constants STEP0..STEP4
  - bit positions for $4017 fields (MODE_BIT=7, INHIBIT_BIT=6)
- Sub-module frame_divider: STEP_PERIOD prescaler with a synchronous clear. Inputs are iTick and clear; output is a one-cycle step strobe.
- Top level holds the step state machine, the fire map and the IRQ flag.

## Test plan
All scenarios use STEP_PERIOD=4 and iTick held high unless noted.
- Reset, then 16 cycles: Q pulses after ticks 4, 8, 12 and 16. H pulses after ticks 8 and 16. oIrq rises after tick 16 and stays high.
- Write 0x80, then 20 cycles: Q+H pulse on the cycle after the write. Then Q after ticks 4, 8 and 12, none at 16, Q+H at 20. oIrq stays 0 and oMode=1.
- IRQ set, then iIrqAck: oIrq drops next cycle. With iIrqAck asserted on the setting cycle, oIrq=1.
- Write 0x40 in 4-step mode through a full frame: Q/H pulses match the first scenario, oIrq stays 0. A write of 0x40 while oIrq=1 clears it.
- iTick low for 10 cycles mid-step: no pulses and cnt holds. With iTick high again, the next Q is delayed by exactly 10 cycles.
- iWrite at the same cycle as tick 4: no step-0 pulse, and the sequence restarts from cnt=0. iReset asserted at tick 7 gives all outputs 0 and a first Q after 4 more ticks.
